// File: rtl/adder_pkg.sv
// Shared constants for the chunked add/subtract datapath.
package adder_pkg;

    // Operation select carried with every beat.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple slice.
// It also exposes the carry into its top bit so that the last slice can
// report signed overflow.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry;

    // Bit-serial ripple through the slice.
    always_comb begin
        s        = '0;
        carry    = '0;
        carry[0] = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co       = carry[CHUNK];
        c_msb_in = carry[CHUNK-1];
    end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined add/subtract unit with a valid/ready handshake on both sides.
// Stage k resolves operand slice k and registers the carry out of that slice.
// The last stage register doubles as the output register.
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    // A beat in flight. b is already inverted for SUB and c already mode-adjusted,
    // so every stage performs a plain add. s collects the resolved slices.
    typedef struct packed {
        logic             sub;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cmsb;
    } beat_t;

    beat_t             in_beat;
    beat_t             stage_q [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    // Convert the incoming operands into an add-only beat.
    always_comb begin
        in_beat     = '0;
        in_beat.sub = (sub == MODE_SUB);
        in_beat.a   = a;
        in_beat.b   = (sub == MODE_SUB) ? ~b : b;
        in_beat.c   = cin ^ (sub == MODE_SUB);
    end

    // Advance chain from the output back to stage 0, so that bubbles collapse.
    // Next-state valid bits are computed in the same block.
    always_comb begin
        adv              = '0;
        load             = '0;
        valid_d          = valid_q;
        adv[STAGES-1]    = !valid_q[STAGES-1] || out_ready;
        for (int unsigned i = 1; i < STAGES; i++) begin
            adv[STAGES-1-i] = !valid_q[STAGES-1-i] || adv[STAGES-i];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                load[k] = adv[k] && in_valid;
            end else begin
                load[k] = adv[k] && valid_q[k-1];
            end
            if (adv[k]) begin
                valid_d[k] = load[k];
            end
        end
    end

    // Valid bits for every stage; the last one is out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam bit LAST = (k == STAGES - 1);

        beat_t            src;
        beat_t            beat_d;
        beat_t            beat_q;
        logic [CHUNK-1:0] slice_s;
        logic             slice_co;
        logic             slice_cmsb;

        if (k == 0) begin : g_first
            assign src = in_beat;
        end else begin : g_rest
            assign src = stage_q[k-1];
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a       (src.a[k*CHUNK +: CHUNK]),
            .b       (src.b[k*CHUNK +: CHUNK]),
            .ci      (src.c),
            .s       (slice_s),
            .co      (slice_co),
            .c_msb_in(slice_cmsb)
        );

        // Merge this slice's result into the travelling beat.
        always_comb begin
            beat_d                      = src;
            beat_d.s[k*CHUNK +: CHUNK]  = slice_s;
            beat_d.c                    = slice_co;
            if (LAST) begin
                beat_d.cmsb = slice_cmsb;
            end
        end

        // Stage data register. Only the output stage is cleared, because it
        // drives the visible sum/cout/ovf ports.
        always_ff @(posedge clk) begin
            if (rst && LAST) begin
                beat_q <= '0;
            end else if (load[k]) begin
                beat_q <= beat_d;
            end
        end

        assign stage_q[k] = beat_q;
    end

    // In SUB mode the internal carry is inverted to form the borrow.
    // Input acceptance is held open during reset.
    assign in_ready  = adv[0] || rst;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = stage_q[STAGES-1].s;
    assign cout      = stage_q[STAGES-1].c ^ stage_q[STAGES-1].sub;
    assign ovf       = stage_q[STAGES-1].c ^ stage_q[STAGES-1].cmsb;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed bench for pipelined_chunk_adder: 16/4 main instance plus a 4/4 instance.
module tb_pipelined_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        w4_in_valid, w4_in_ready, w4_cin, w4_sub, w4_out_valid, w4_out_ready, w4_cout, w4_ovf;
    logic [3:0]  w4_a, w4_b, w4_sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .cin(w4_cin), .sub(w4_sub),
        .out_valid(w4_out_valid), .out_ready(w4_out_ready),
        .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf)
    );

    // Hand-computed back-to-back vectors: a, b, cin, sub -> sum, cout, ovf
    logic [15:0] v_a   [8] = '{16'h0001, 16'h0010, 16'hFFFF, 16'h0000, 16'h4000, 16'h1000, 16'h00FF, 16'h7FFF};
    logic [15:0] v_b   [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0001, 16'h4000, 16'h0FFF, 16'h0F01, 16'hFFFF};
    logic        v_cin [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        v_sub [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] v_s   [8] = '{16'h0003, 16'h000F, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h1000, 16'h8000};
    logic        v_co  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        v_ov  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Issue one beat into an empty pipeline and wait (bounded) for its result.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin, input logic tsub,
                          output logic [15:0] rs, output logic rc, output logic ro, output logic got);
        rs = '0; rc = 1'b0; ro = 1'b0; got = 1'b0;
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1; rs = sum; rc = cout; ro = ovf;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; w4_in_valid = 1'b0; w4_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (sum !== 16'h0000) begin fails++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b expected 0", cout); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (w4_out_valid !== 1'b0) begin fails++; $display("FAIL reset_w4_out_valid: got %b expected 0", w4_out_valid); end
        rst = 1'b0;
    endtask

    task automatic test_latency_add;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            tests++;
            if (out_valid !== (i == 3)) begin
                fails++; $display("FAIL lat_out_valid edge+%0d: got %b expected %b", i, out_valid, (i == 3));
            end
        end
        tests++; if (sum !== 16'h0000) begin fails++; $display("FAIL lat_sum: got %h expected 0000", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL lat_cout: got %b expected 1", cout); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL lat_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_add_vectors;
        logic [15:0] rs; logic rc, ro, got;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL add1_timeout: got %b expected 1", got); end
        tests++; if (rs !== 16'h8000) begin fails++; $display("FAIL add1_sum: got %h expected 8000", rs); end
        tests++; if (rc !== 1'b0) begin fails++; $display("FAIL add1_cout: got %b expected 0", rc); end
        tests++; if (ro !== 1'b1) begin fails++; $display("FAIL add1_ovf: got %b expected 1", ro); end
        run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, rs, rc, ro, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL add2_timeout: got %b expected 1", got); end
        tests++; if (rs !== 16'h2234) begin fails++; $display("FAIL add2_sum: got %h expected 2234", rs); end
        tests++; if (rc !== 1'b0) begin fails++; $display("FAIL add2_cout: got %b expected 0", rc); end
        tests++; if (ro !== 1'b0) begin fails++; $display("FAIL add2_ovf: got %b expected 0", ro); end
    endtask

    task automatic test_sub_vectors;
        logic [15:0] rs; logic rc, ro, got;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL sub1_timeout: got %b expected 1", got); end
        tests++; if (rs !== 16'hFFFE) begin fails++; $display("FAIL sub1_sum: got %h expected fffe", rs); end
        tests++; if (rc !== 1'b1) begin fails++; $display("FAIL sub1_borrow: got %b expected 1", rc); end
        tests++; if (ro !== 1'b0) begin fails++; $display("FAIL sub1_ovf: got %b expected 0", ro); end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL sub2_timeout: got %b expected 1", got); end
        tests++; if (rs !== 16'h7FFF) begin fails++; $display("FAIL sub2_sum: got %h expected 7fff", rs); end
        tests++; if (rc !== 1'b0) begin fails++; $display("FAIL sub2_borrow: got %b expected 0", rc); end
        tests++; if (ro !== 1'b1) begin fails++; $display("FAIL sub2_ovf: got %b expected 1", ro); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] gs[$]; logic gc[$]; logic go[$]; int gcyc[$];
        @(negedge clk);
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = v_a[i]; b = v_b[i]; cin = v_cin[i]; sub = v_sub[i]; in_valid = 1'b1;
                    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready beat %0d: got %b expected 1", i, in_ready); end
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        gs.push_back(sum); gc.push_back(cout); go.push_back(ovf); gcyc.push_back(c);
                    end
                end
            end
        join
        tests++; if (gs.size() != 8) begin fails++; $display("FAIL b2b_count: got %0d expected 8", gs.size()); end
        for (int j = 0; j < 8 && j < gs.size(); j++) begin
            tests++; if (gs[j] !== v_s[j]) begin fails++; $display("FAIL b2b_sum %0d: got %h expected %h", j, gs[j], v_s[j]); end
            tests++; if (gc[j] !== v_co[j]) begin fails++; $display("FAIL b2b_cout %0d: got %b expected %b", j, gc[j], v_co[j]); end
            tests++; if (go[j] !== v_ov[j]) begin fails++; $display("FAIL b2b_ovf %0d: got %b expected %b", j, go[j], v_ov[j]); end
            tests++; if (gcyc[j] != gcyc[0] + j) begin fails++; $display("FAIL b2b_cycle %0d: got %0d expected %0d", j, gcyc[j], gcyc[0] + j); end
        end
    endtask

    task automatic test_stall;
        logic [15:0] expq[$]; logic [15:0] gotq[$];
        int accepted; logic held; logic [15:0] hs;
        accepted = 0; held = 1'b0; hs = '0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            if (in_ready) begin
                accepted++; expq.push_back(16'(a + 16'h0001));
            end
            if (out_valid) begin
                if (!held) begin
                    held = 1'b1; hs = sum;
                end else begin
                    tests++; if (sum !== hs) begin fails++; $display("FAIL stall_hold cycle %0d: got %h expected %h", i, sum, hs); end
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++; if (accepted != 4) begin fails++; $display("FAIL stall_accepted: got %0d expected 4", accepted); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
        tests++; if (sum !== 16'h0101) begin fails++; $display("FAIL stall_head_sum: got %h expected 0101", sum); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready) gotq.push_back(sum);
            @(negedge clk);
        end
        tests++; if (gotq.size() != 4) begin fails++; $display("FAIL stall_drain_count: got %0d expected 4", gotq.size()); end
        for (int j = 0; j < 4 && j < gotq.size() && j < expq.size(); j++) begin
            tests++; if (gotq[j] !== expq[j]) begin fails++; $display("FAIL stall_drain %0d: got %h expected %h", j, gotq[j], expq[j]); end
        end
    endtask

    task automatic test_reset_mid;
        int stale;
        stale = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'hAAA0 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        tests++; if (stale != 0) begin fails++; $display("FAIL midrst_stale: got %0d expected 0", stale); end
    endtask

    task automatic test_width4;
        logic [3:0] ta [3] = '{4'hF, 4'h7, 4'h3};
        logic [3:0] tb_[3] = '{4'h1, 4'h1, 4'h5};
        logic       ts [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] es [3] = '{4'h0, 4'h8, 4'hE};
        logic       ec [3] = '{1'b1, 1'b0, 1'b1};
        logic       eo [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w4_a = ta[i]; w4_b = tb_[i]; w4_cin = 1'b0; w4_sub = ts[i]; w4_in_valid = 1'b1;
            tests++; if (w4_in_ready !== 1'b1) begin fails++; $display("FAIL w4_in_ready %0d: got %b expected 1", i, w4_in_ready); end
            tests++; if (w4_out_valid !== 1'b0) begin fails++; $display("FAIL w4_pre_valid %0d: got %b expected 0", i, w4_out_valid); end
            @(negedge clk);
            w4_in_valid = 1'b0;
            tests++; if (w4_out_valid !== 1'b1) begin fails++; $display("FAIL w4_latency %0d: got %b expected 1", i, w4_out_valid); end
            tests++; if (w4_sum !== es[i]) begin fails++; $display("FAIL w4_sum %0d: got %h expected %h", i, w4_sum, es[i]); end
            tests++; if (w4_cout !== ec[i]) begin fails++; $display("FAIL w4_cout %0d: got %b expected %b", i, w4_cout, ec[i]); end
            tests++; if (w4_ovf !== eo[i]) begin fails++; $display("FAIL w4_ovf %0d: got %b expected %b", i, w4_ovf, eo[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        w4_in_valid = 1'b0; w4_out_ready = 1'b1; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_sub = 1'b0;
        test_reset();
        test_latency_add();
        test_add_vectors();
        test_sub_vectors();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
